// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 4;

  // Opcode field is the top OP_W bits of an instruction word.
  localparam int OP_W = 5;
  localparam logic [OP_W-1:0] HALT_OP = 5'b00000;
  localparam logic [OP_W-1:0] NOP_OP  = 5'b00001;

  // IDLE: may issue a read; WAIT: read outstanding, response wanted;
  // DROP: read outstanding, response will be discarded; HALTED: parked on HALT.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    DROP   = 2'd2,
    HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the redirect, memory and issue signals of the fetch queue.
interface fetch_queue_if #(
  parameter int WIDTH = fetch_pkg::DEF_WIDTH
) ();

  logic [WIDTH-1:0] new_PC;
  logic             take_new_PC;
  logic             stall;
  logic [WIDTH-1:0] mem_data;
  logic             mem_done;
  logic             mem_err;
  logic             mem_rd;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] PC_inc;
  logic             instr_valid;
  logic             halt;
  logic             err;

  // The fetch queue itself.
  modport master (
    input  new_PC, take_new_PC, stall, mem_data, mem_done, mem_err,
    output mem_rd, mem_addr, instr, PC_inc, instr_valid, halt, err
  );

  // The surrounding pipeline and memory system.
  modport slave (
    output new_PC, take_new_PC, stall, mem_data, mem_done, mem_err,
    input  mem_rd, mem_addr, instr, PC_inc, instr_valid, halt, err
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular queue of {instruction, PC+2} pairs with push, pop and flush.
module fetch_fifo #(
  parameter int WIDTH = fetch_pkg::DEF_WIDTH,
  parameter int DEPTH = fetch_pkg::DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_instr,
  input  logic [WIDTH-1:0] push_pc_inc,
  output logic [WIDTH-1:0] head_instr,
  output logic [WIDTH-1:0] head_pc_inc,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Write the pushed entry at the tail.
  // NOTE: storage has no reset; count and the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_ptr] <= push_instr;
      pc_mem[tail_ptr]    <= push_pc_inc;
    end
  end

  // Advance pointers and occupancy; flush empties the queue outright.
  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= ptr_inc(tail_ptr);
      if (pop)  head_ptr <= ptr_inc(head_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_instr  = instr_mem[head_ptr];
  assign head_pc_inc = pc_mem[head_ptr];
  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch: one outstanding memory read feeding a small queue,
// with redirect flush and HALT parking.
module fetch_queue #(
  parameter int         WIDTH   = fetch_pkg::DEF_WIDTH,
  parameter int         DEPTH   = fetch_pkg::DEF_DEPTH,
  parameter logic [4:0] HALT_OP = fetch_pkg::HALT_OP,
  parameter logic [4:0] NOP_OP  = fetch_pkg::NOP_OP
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);

  import fetch_pkg::*;

  state_e           state;
  state_e           state_next;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] pc_plus2;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] rd_addr;
  logic [WIDTH-1:0] head_instr;
  logic [WIDTH-1:0] head_pc_inc;
  logic             fifo_empty;
  logic             fifo_full;
  logic             rd_req;
  logic             issue;
  logic             push;
  logic             pop;
  logic             flush;
  logic             valid;
  logic             head_halt;
  logic             data_halt;
  logic             err_flag;

  assign pc_plus2  = fetch_pc + WIDTH'(2);
  assign data_halt = (bus.mem_data[WIDTH-1 -: OP_W] == HALT_OP);
  assign head_halt = (head_instr[WIDTH-1 -: OP_W] == HALT_OP);

  // A redirect hides and discards whatever is queued in the same cycle.
  assign flush = bus.take_new_PC;
  assign valid = ~fifo_empty & ~bus.take_new_PC;
  // The HALT entry stays at the head until a redirect or reset clears it.
  assign pop   = valid & ~bus.stall & ~head_halt;

  fetch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .flush       (flush),
    .push_instr  (bus.mem_data),
    .push_pc_inc (pc_plus2),
    .head_instr  (head_instr),
    .head_pc_inc (head_pc_inc),
    .empty       (fifo_empty),
    .full        (fifo_full)
  );

  // Next state, read request and push decision; redirect outranks everything.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_next = state;
    rd_req     = 1'b0;
    rd_addr    = req_addr;
    issue      = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        rd_addr = fetch_pc;
        // Gating by rst keeps mem_rd low while reset is held.
        if (rst && !bus.take_new_PC && !fifo_full) begin
          rd_req     = 1'b1;
          issue      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        rd_req = 1'b1;
        if (bus.take_new_PC) begin
          state_next = bus.mem_done ? IDLE : DROP;
        end else if (bus.mem_done) begin
          push       = 1'b1;
          state_next = data_halt ? HALTED : IDLE;
        end
      end
      DROP: begin
        rd_req = 1'b1;
        if (bus.mem_done) state_next = IDLE;
      end
      HALTED: begin
        if (bus.take_new_PC) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, fetch PC, held read address and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= '0;
      req_addr <= '0;
      err_flag <= 1'b0;
    end else begin
      state <= state_next;
      if (bus.take_new_PC) fetch_pc <= bus.new_PC;
      else if (push)       fetch_pc <= pc_plus2;
      if (issue)        req_addr <= fetch_pc;
      if (bus.mem_err)  err_flag <= 1'b1;
    end
  end

  assign bus.mem_rd      = rd_req;
  assign bus.mem_addr    = rd_addr;
  assign bus.instr_valid = valid;
  assign bus.halt        = valid & head_halt;
  assign bus.instr       = valid ? head_instr : {NOP_OP, {(WIDTH-OP_W){1'b0}}};
  assign bus.PC_inc      = valid ? head_pc_inc : '0;
  assign bus.err         = err_flag;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a memory model serves reads from a plan queue
// and checks addresses; a monitor compares every popped instruction against
// an expected-instruction queue filled by the stimulus.
module tb_fetch_queue;

  localparam int W = 16;
  localparam int D = 4;

  typedef struct {
    logic [W-1:0] addr;
    logic [W-1:0] data;
    int           lat;
  } rd_t;

  typedef struct {
    logic [W-1:0] instr;
    logic [W-1:0] pc_inc;
  } ex_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.WIDTH(W)) bus ();

  fetch_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  rd_t plan[$];
  ex_t exp_q[$];
  int  total      = 0;
  int  bad        = 0;
  int  reads_seen = 0;
  bit  mem_busy   = 1'b0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic add_rd(input logic [W-1:0] addr, input logic [W-1:0] data, input int lat);
    rd_t r;
    r.addr = addr;
    r.data = data;
    r.lat  = lat;
    plan.push_back(r);
  endtask

  task automatic add_exp(input logic [W-1:0] instr, input logic [W-1:0] pc_inc);
    ex_t e;
    e.instr  = instr;
    e.pc_inc = pc_inc;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((plan.size() != 0 || exp_q.size() != 0 || mem_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (plan.size() != 0 || exp_q.size() != 0 || mem_busy) begin
      bad++;
      $display("FAIL %s: timeout after %0d cycles, reads left=%0d instrs left=%0d, want 0/0",
               name, n, plan.size(), exp_q.size());
    end
  endtask

  // Memory model: accept a planned read, hold it for lat cycles, then pulse mem_done.
  initial begin : mem_model
    rd_t          cur;
    int           wait_cnt;
    logic [W-1:0] cur_addr;
    wait_cnt     = 0;
    cur_addr     = '0;
    bus.mem_done = 1'b0;
    bus.mem_data = '0;
    forever begin
      @(negedge clk);
      bus.mem_done = 1'b0;
      if (!rst_n) begin
        mem_busy = 1'b0;
      end else if (mem_busy) begin
        check_bit("rd_hold", bus.mem_rd, 1'b1);
        check("addr_hold", bus.mem_addr, cur_addr);
        wait_cnt--;
        if (wait_cnt == 0) begin
          bus.mem_data = cur.data;
          bus.mem_done = 1'b1;
          mem_busy     = 1'b0;
        end
      end else if (bus.mem_rd && plan.size() > 0) begin
        cur = plan.pop_front();
        check("rd_addr", bus.mem_addr, cur.addr);
        cur_addr = cur.addr;
        wait_cnt = cur.lat;
        mem_busy = 1'b1;
        reads_seen++;
      end
    end
  end

  // Monitor: every instruction the DUT hands off must match the next expected one.
  initial begin : monitor
    ex_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.instr_valid && !bus.stall && !bus.halt) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got instr=%h pc_inc=%h, want no instruction",
                   bus.instr, bus.PC_inc);
        end else begin
          e = exp_q.pop_front();
          check("instr", bus.instr, e.instr);
          check("pc_inc", bus.PC_inc, e.pc_inc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int base;
    int n;
    bus.new_PC      = '0;
    bus.take_new_PC = 1'b0;
    bus.stall       = 1'b0;
    bus.mem_err     = 1'b0;

    // Reset values.
    smp();
    smp();
    check_bit("rst_mem_rd", bus.mem_rd, 1'b0);
    check_bit("rst_valid", bus.instr_valid, 1'b0);
    check_bit("rst_halt", bus.halt, 1'b0);
    check("rst_instr", bus.instr, 16'h0800);
    check("rst_pc_inc", bus.PC_inc, 16'h0000);
    check_bit("rst_err", bus.err, 1'b0);

    // Three sequential fetches with single-cycle memory.
    cyc();
    add_rd(16'h0000, 16'h0800, 1);
    add_rd(16'h0002, 16'h0801, 1);
    add_rd(16'h0004, 16'h0802, 1);
    add_exp(16'h0800, 16'h0002);
    add_exp(16'h0801, 16'h0004);
    add_exp(16'h0802, 16'h0006);
    rst_n = 1'b1;
    smp();
    check_bit("first_rd", bus.mem_rd, 1'b1);
    check_bit("valid_at_issue", bus.instr_valid, 1'b0);
    smp();
    check_bit("valid_at_done", bus.instr_valid, 1'b0);
    smp();
    check_bit("valid_after_done", bus.instr_valid, 1'b1);
    drain("seq_fetch", 30);

    // HALT fetched at 0x0006 parks the queue until a redirect.
    cyc();
    add_rd(16'h0006, 16'h0000, 1);
    n = 0;
    while (!bus.halt && n < 10) begin
      smp();
      n++;
    end
    check_bit("halt_set", bus.halt, 1'b1);
    check("halt_instr", bus.instr, 16'h0000);
    check("halt_pc_inc", bus.PC_inc, 16'h0008);
    for (int i = 0; i < 5; i++) begin
      smp();
      check_bit("halt_held", bus.halt, 1'b1);
      check_bit("halt_no_rd", bus.mem_rd, 1'b0);
    end
    cyc();
    add_rd(16'h0020, 16'h1234, 1);
    add_exp(16'h1234, 16'h0022);
    bus.new_PC      = 16'h0020;
    bus.take_new_PC = 1'b1;
    smp();
    check_bit("redir_valid", bus.instr_valid, 1'b0);
    check_bit("redir_halt", bus.halt, 1'b0);
    check_bit("redir_no_rd", bus.mem_rd, 1'b0);
    cyc();
    bus.take_new_PC = 1'b0;
    smp();
    check_bit("halt_cleared", bus.halt, 1'b0);
    check_bit("rd_after_halt", bus.mem_rd, 1'b1);
    drain("halt_exit", 30);

    // Redirect while a read to 0x0022 is outstanding; its late response is dropped.
    cyc();
    add_rd(16'h0022, 16'h5555, 3);
    add_rd(16'h0100, 16'h0C00, 1);
    add_exp(16'h0C00, 16'h0102);
    bus.new_PC      = 16'h0100;
    bus.take_new_PC = 1'b1;
    smp();
    check_bit("wait_redir_valid", bus.instr_valid, 1'b0);
    check_bit("wait_redir_rd", bus.mem_rd, 1'b1);
    cyc();
    bus.take_new_PC = 1'b0;
    drain("drop_resp", 30);

    // Stall fills the queue: exactly DEPTH reads, then no reads while full.
    cyc();
    bus.stall = 1'b1;
    base = reads_seen;
    add_rd(16'h0102, 16'h0900, 1);
    add_rd(16'h0104, 16'h0901, 1);
    add_rd(16'h0106, 16'h0902, 1);
    add_rd(16'h0108, 16'h0903, 1);
    add_rd(16'h010A, 16'h0904, 1);
    add_exp(16'h0900, 16'h0104);
    add_exp(16'h0901, 16'h0106);
    add_exp(16'h0902, 16'h0108);
    add_exp(16'h0903, 16'h010A);
    add_exp(16'h0904, 16'h010C);
    n = 0;
    while (plan.size() > 1 && n < 30) begin
      smp();
      n++;
    end
    smp();
    smp();
    for (int i = 0; i < 6; i++) begin
      smp();
      check_bit("full_no_rd", bus.mem_rd, 1'b0);
      check("full_head", bus.instr, 16'h0900);
    end
    check_int("reads_while_full", reads_seen - base, D);
    cyc();
    bus.stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      smp();
      check_bit("pop_per_cycle", bus.instr_valid, 1'b1);
    end
    drain("stall_release", 30);

    // Fetch PC wraps from 0xFFFE to 0x0000.
    cyc();
    add_rd(16'h010C, 16'hDEAD, 1);
    add_rd(16'hFFFE, 16'h0A00, 1);
    add_rd(16'h0000, 16'h0A01, 1);
    add_exp(16'h0A00, 16'h0000);
    add_exp(16'h0A01, 16'h0002);
    bus.new_PC      = 16'hFFFE;
    bus.take_new_PC = 1'b1;
    cyc();
    bus.take_new_PC = 1'b0;
    drain("wrap", 30);

    // Sticky error flag.
    cyc();
    bus.mem_err = 1'b1;
    cyc();
    bus.mem_err = 1'b0;
    smp();
    check_bit("err_set", bus.err, 1'b1);
    repeat (3) smp();
    check_bit("err_held", bus.err, 1'b1);

    // Reset in the middle of a read abandons it; fetch restarts at 0.
    cyc();
    add_rd(16'h0002, 16'h7777, 5);
    smp();
    smp();
    cyc();
    rst_n = 1'b0;
    smp();
    check_bit("rst2_err", bus.err, 1'b0);
    check_bit("rst2_mem_rd", bus.mem_rd, 1'b0);
    check_bit("rst2_valid", bus.instr_valid, 1'b0);
    check("rst2_instr", bus.instr, 16'h0800);
    check("rst2_pc_inc", bus.PC_inc, 16'h0000);
    plan.delete();
    exp_q.delete();
    cyc();
    add_rd(16'h0000, 16'h0801, 1);
    add_exp(16'h0801, 16'h0002);
    rst_n = 1'b1;
    smp();
    check_bit("restart_rd", bus.mem_rd, 1'b1);
    drain("restart", 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter WIDTH, default 16, instruction/PC width in bits (WIDTH >= 8).
REQ-002 Parameter DEPTH, default 4, prefetch queue entries (DEPTH >= 2).
REQ-003 Parameter HALT_OP, default 5'b00000, opcode in bits [WIDTH-1:WIDTH-5] decoded as HALT.
REQ-004 Parameter NOP_OP, default 5'b00001, opcode of the NOP emitted when no valid instruction is presented.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 new_PC  in  WIDTH  redirect target.
REQ-009 take_new_PC  in  1  redirect request.
REQ-010 stall  in  1  downstream cannot accept the head instruction.
REQ-011 mem_data  in  WIDTH  instruction memory read data.
REQ-012 mem_done  in  1  read completes this cycle, mem_data valid.
REQ-013 mem_err  in  1  memory system error.
REQ-014 mem_rd  out  1  read request.
REQ-015 mem_addr  out  WIDTH  read address.
REQ-016 instr  out  WIDTH  head instruction, or NOP.
REQ-017 PC_inc  out  WIDTH  address of the head instruction + 2.
REQ-018 instr_valid  out  1  instr is a real queued instruction.
REQ-019 halt  out  1  head instruction is HALT.
REQ-020 err  out  1  sticky error flag.

Function
REQ-021 The block SHALL hold a fetch PC register, a DEPTH-entry circular queue of {instr, PC+2} and a state machine with states IDLE, WAIT, DROP and HALTED.
REQ-022 In IDLE with count < DEPTH and no redirect, the block SHALL assert mem_rd with mem_addr = fetch PC and enter WAIT.
REQ-023 In WAIT and DROP, mem_rd and mem_addr SHALL be held stable until mem_done.
REQ-024 On mem_done in WAIT without redirect:
- {mem_data, fetch PC+2} SHALL be pushed.
- Fetch PC SHALL advance by 2, modulo 2^WIDTH.
- Next state SHALL be HALTED if the pushed opcode == HALT_OP, else IDLE.
REQ-025 Issue latency: a pushed instruction SHALL appear on instr with instr_valid the cycle after mem_done.
REQ-026 instr_valid SHALL equal (count > 0) & ~take_new_PC.
REQ-027 When instr_valid = 0, instr SHALL be {NOP_OP, zeros}.
REQ-028 Pop SHALL occur when instr_valid & ~stall & ~halt.
REQ-029 Simultaneous push and pop SHALL leave count unchanged.
REQ-030 A new read SHALL never be issued when count == DEPTH.
REQ-031 halt SHALL equal instr_valid & (head opcode == HALT_OP).
REQ-032 The HALT entry SHALL never be popped.
REQ-033 HALTED SHALL issue no reads and SHALL be left only by redirect or reset.
REQ-034 Redirect (take_new_PC = 1) SHALL take priority over push, pop and issue:
- Queue flushed (count = 0).
- Fetch PC loaded with new_PC.
- WAIT without mem_done goes to DROP.
- WAIT with mem_done, IDLE and HALTED go to IDLE, and any response that cycle is discarded.
REQ-035 In DROP, the response on mem_done SHALL be discarded and the next state SHALL be IDLE.
REQ-036 A redirect while in DROP SHALL reload fetch PC and remain in DROP.
REQ-037 err SHALL set on mem_err and hold until reset.

Reset
REQ-038 While rst = 0:
- Fetch PC = 0, count = 0, head and tail pointers = 0, state = IDLE.
- err = 0, mem_rd = 0, instr_valid = 0, halt = 0.
- instr = {NOP_OP, zeros}, PC_inc = 0.
REQ-039 Reset asserted mid-read SHALL abandon the read with no state retained.
REQ-040 The first read SHALL issue in the first cycle after rst deasserts, to address 0.

Structure
REQ-041 Package fetch_pkg SHALL hold the state enumeration, HALT_OP, NOP_OP and the default WIDTH/DEPTH constants.
REQ-042 The queue SHALL be a sub-module fetch_fifo containing the storage, head/tail pointers and count, with push/pop/flush controls.

Verification
REQ-043 The bench SHALL cover these directed scenarios:
- Reset, mem returns 0x0800, 0x0801, 0x0802 with 1-cycle done -> mem_addr 0x0000, 0x0002, 0x0004; instr_valid the cycle after each done; PC_inc 0x0002, 0x0004, 0x0006.
- stall held high, DEPTH = 4 -> exactly 4 reads issued, mem_rd low while full; stall released -> one pop per cycle, reads resume.
- take_new_PC with new_PC = 0x0100 while in WAIT, mem_done 3 cycles later -> that response discarded; next mem_addr = 0x0100; instr_valid 0 in the redirect cycle.
- mem_data = 0x0000 (HALT) at PC 0x0006 -> halt = 1 and held; no further mem_rd; redirect to 0x0020 -> halt = 0, fetch from 0x0020.
- Fetch PC 0xFFFE -> next mem_addr 0x0000; mem_err pulse -> err stays 1 until rst = 0.
